// File: rtl/cdc_capture_queue.sv
// Destination-domain capture-and-queue stage: per-channel toggle edges trigger a settled
// capture of quasi-static data, which is arbitrated into a tagged FWFT FIFO.
module cdc_capture_queue #(
   parameter int NUM_CHANNELS  = 4,
   parameter int NUM_BITS      = 32,
   parameter int FIFO_DEPTH    = 8,
   parameter int SETTLE_CYCLES = 0,
   localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_CHANNELS-1:0]          toggle_in,
   input  logic [NUM_CHANNELS*NUM_BITS-1:0] bits_in,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [NUM_BITS-1:0]              out_bits,
   output logic [CH_W-1:0]                  out_channel,
   output logic [LVL_W-1:0]                 level,
   output logic [NUM_CHANNELS-1:0]          overflow,
   input  logic                             overflow_clear
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
   localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, SETTLE, PENDING} chState_t;

   chState_t                    state_q [NUM_CHANNELS];
   chState_t                    state_d [NUM_CHANNELS];
   logic [3:0]                  count_q [NUM_CHANNELS];
   logic [3:0]                  count_d [NUM_CHANNELS];
   logic [NUM_BITS-1:0]         hold_q  [NUM_CHANNELS];
   logic [NUM_BITS-1:0]         hold_d  [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]     lastToggle_q;
   logic [NUM_CHANNELS-1:0]     overflow_q, overflow_d;
   logic [NUM_CHANNELS-1:0]     chEvent, grant, ovfSet, startCap;
   logic                        push, pop, canWrite;
   logic [CH_W-1:0]             grantIdx;
   logic [NUM_BITS-1:0]         grantBits;
   logic [CH_W+NUM_BITS-1:0]    mem [FIFO_DEPTH];
   logic [PTR_W-1:0]            wrPtr_q, rdPtr_q;
   logic [LVL_W-1:0]            level_q, level_d;

   // A pop in the same cycle frees a slot, so a full queue can still accept a grant.
   always_comb begin
      chEvent   = toggle_in ^ lastToggle_q;
      pop       = out_valid & out_ready;
      canWrite  = (level_q != FULL_LEVEL) | pop;
      grant     = '0;
      grantIdx  = '0;
      grantBits = '0;
      push      = 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (!push && canWrite && state_q[c] == PENDING) begin
            grant[c]  = 1'b1;
            grantIdx  = CH_W'(c);
            grantBits = hold_q[c];
            push      = 1'b1;
         end
      end
   end

   always_comb begin
      ovfSet   = '0;
      startCap = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         state_d[c] = state_q[c];
         count_d[c] = count_q[c];
         hold_d[c]  = hold_q[c];
         case (state_q[c])
            IDLE: startCap[c] = chEvent[c];
            SETTLE: begin
               if (chEvent[c]) begin
                  count_d[c] = SETTLE_INIT;
                  ovfSet[c]  = 1'b1;
               end else if (count_q[c] == 4'd1) begin
                  hold_d[c]  = bits_in[c*NUM_BITS +: NUM_BITS];
                  state_d[c] = PENDING;
               end else begin
                  count_d[c] = count_q[c] - 4'd1;
               end
            end
            PENDING: begin
               if (grant[c]) begin
                  state_d[c]  = IDLE;
                  startCap[c] = chEvent[c];
               end else if (chEvent[c]) begin
                  ovfSet[c]   = 1'b1;
                  startCap[c] = 1'b1;
               end
            end
            default: state_d[c] = IDLE;
         endcase
         // A fresh event restarts the capture path, overriding whatever the state chose.
         if (startCap[c]) begin
            if (SETTLE_CYCLES == 0) begin
               hold_d[c]  = bits_in[c*NUM_BITS +: NUM_BITS];
               state_d[c] = PENDING;
            end else begin
               count_d[c] = SETTLE_INIT;
               state_d[c] = SETTLE;
            end
         end
      end
      overflow_d = (overflow_q & ~{NUM_CHANNELS{overflow_clear}}) | ovfSet;
   end

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Reloading lastToggle from the live input hides edges that were in flight across reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_q[c] <= IDLE;
            count_q[c] <= '0;
            hold_q[c]  <= '0;
         end
         lastToggle_q <= toggle_in;
         overflow_q   <= '0;
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         level_q      <= '0;
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_q[c] <= state_d[c];
            count_q[c] <= count_d[c];
            hold_q[c]  <= hold_d[c];
         end
         lastToggle_q <= toggle_in;
         overflow_q   <= overflow_d;
         level_q      <= level_d;
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) mem[wrPtr_q] <= {grantIdx, grantBits};
   end

   assign out_valid = (level_q != '0);
   assign {out_channel, out_bits} = out_valid ? mem[rdPtr_q] : '0;
   assign level    = level_q;
   assign overflow = overflow_q;

endmodule

// File: doc/cdc_capture_queue.md
# cdc_capture_queue

Multi-channel capture-and-queue stage for open-loop clock-domain crossings. It sits entirely in the destination clock domain, downstream of per-channel `cdc_sync_bits` toggle synchronisers. Each channel's toggle edge triggers a settled capture of that channel's quasi-static data bus. Captured words are queued, tagged with their channel index, into a FIFO with ready/valid backpressure, and lost updates are flagged per channel.

## Interface
- `NUM_CHANNELS`, 4: independent source channels, 1..16.
- `NUM_BITS`, 32: data width per channel.
- `FIFO_DEPTH`, 8: queue entries; power of two, ≥2.
- `SETTLE_CYCLES`, 0: extra clk cycles between toggle-edge detection and data capture, 0..15.
- Derived: `CH_W` = max(1, clog2(`NUM_CHANNELS`)); `LVL_W` = clog2(`FIFO_DEPTH`)+1.

Ports:
- `clk`  in  1: destination-domain clock, the only clock.
- `reset`  in  1: synchronous, active-high.
- `toggle_in`  in  `NUM_CHANNELS`: synchronised load toggles, one per channel.
- `bits_in`  in  `NUM_CHANNELS*NUM_BITS`: channel c occupies bits [c*`NUM_BITS` +: `NUM_BITS`].
- `out_valid`  out  1: queue head valid.
- `out_ready`  in  1: consumer accepts the head.
- `out_bits`  out  `NUM_BITS`: head data.
- `out_channel`  out  `CH_W`: head channel index.
- `level`  out  `LVL_W`: current queue occupancy.
- `overflow`  out  `NUM_CHANNELS`: sticky lost-update flags.
- `overflow_clear`  in  1: clears all `overflow` bits.

## Operation
- **Edge detect.** `last_toggle` holds the previous `toggle_in`. An event on channel c is `toggle_in[c] != last_toggle[c]`.
- **Per-channel FSM: IDLE, SETTLE, PENDING.** Each channel has a 4-bit settle counter and a `NUM_BITS` hold register.
- **IDLE + event:**
  - If `SETTLE_CYCLES`=0: capture `bits_in` slice into the hold register and go to PENDING.
  - Otherwise: counter ← `SETTLE_CYCLES`, go to SETTLE.
- **SETTLE:**
  - Counter decrements each cycle.
  - In the cycle the counter equals 1: capture the slice and go to PENDING.
  - An event during SETTLE reloads the counter and sets `overflow[c]`, because the earlier load is lost.
- **PENDING:**
  - Waits for a grant.
  - An event while PENDING and not granted discards the held value, sets `overflow[c]`, and re-enters the capture path as from IDLE.
- **Arbiter.**
  - Grants the lowest-indexed PENDING channel.
  - At most one grant per cycle.
  - A grant is issued only if the FIFO can accept a write: `level < FIFO_DEPTH`, or a pop occurs in the same cycle.
  - On a grant, {channel index, hold register} is written to the FIFO and the channel returns to IDLE.
  - An event on the granted channel in the same cycle is handled as from IDLE and does not set overflow.
- **FIFO full.** PENDING channels stall without loss. Loss occurs only through a new event.
- **Overflow clear.** `overflow_clear` zeroes `overflow`. If a set and a clear land on the same bit in the same cycle, the set wins.
- **Output.** The FIFO is first-word-fall-through.
  - `out_valid` = (`level` != 0).
  - Pop on `out_valid & out_ready`.
  - Simultaneous push and pop leaves `level` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `out_ready` while empty has no effect.
- **Reset:**
  - All channels go to IDLE.
  - FIFO is emptied.
  - `last_toggle` ← `toggle_in`, so edges in flight across reset are not reported.
  - Captured and queued data is discarded.

## Timing
- **Reset values:** `out_valid` 0, `out_bits` 0, `out_channel` 0, `level` 0, `overflow` 0.
- **Minimum latency** (idle, empty, no contention): the edge is visible on `toggle_in` in cycle n. The capture, grant, and FIFO write then complete at these edges:
  - `SETTLE_CYCLES`=0: capture at edge n; grant/write at edge n+1; `out_valid` high in cycle n+2.
  - `SETTLE_CYCLES`=S>0: capture at edge n+S; `out_valid` high in cycle n+S+2.
- **Contention:** each additional lower-indexed PENDING channel adds 1 cycle.
- **Throughput:** one enqueue and one dequeue per cycle.
- **Source rate rule:** the toggle period on any channel must exceed S+3 clk cycles to guarantee no overflow with an always-ready consumer.
- **Queue outputs:** `level`, `out_bits`, and `out_channel` are registered or FIFO-read with no combinational path from `toggle_in` or `bits_in`. `out_valid` depends only on `level`.

## Test plan
- **Single channel.** `NUM_CHANNELS`=4, S=0, `out_ready`=1, toggle ch2 with `bits_in` slice 0xDEADBEEF -> `out_valid` high in cycle n+2 for 1 cycle, `out_bits`=0xDEADBEEF, `out_channel`=2, `overflow`=0.
- **Simultaneous events.** Toggle ch3, ch0, ch1 in the same cycle with slices 0x3, 0x0, 0x1 -> dequeue order ch0, ch1, ch3 on consecutive cycles with matching data.
- **Settle delay.** S=3: change ch1 slice to 0xAAAA0001 one cycle after the toggle edge -> queued value is 0xAAAA0001, and `out_valid` rises in cycle n+5.
- **Full and backpressure.** `FIFO_DEPTH`=8, `out_ready`=0, 10 single-toggle events across channels -> `level` saturates at 8, 2 entries remain PENDING, no overflow. Raise `out_ready` -> all 10 drain in arbiter order.
- **Lost update.** `out_ready`=0 with FIFO full, toggle ch0 twice (0x11, then 0x22) -> `overflow[0]`=1 and only 0x22 is enqueued. Pulse `overflow_clear` coincident with a new ch0 loss -> bit stays 1. Clear alone -> 0.
- **Reset mid-operation.** Assert `reset` with `level`=5 and ch2 in SETTLE, flipping ch1 toggle during reset -> after release `level`=0, `out_valid`=0, and no ch1 entry ever appears.
